pwm_dac_multi: RTL and testbench

//  Multi-channel PWM DAC, successor to the single-channel PWM DAC. One window counter
//  is shared by all channels. Codes arrive as one frame per window over a valid/ready

---
 rtl/pwm_dac_pkg.sv | 16 +
 rtl/pwm_dac_chan.sv | 47 ++++
 rtl/pwm_dac_multi.sv | 68 ++++++
 tb/tb_pwm_dac_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared helpers for the multi-channel PWM DAC (code width, window end, clamp).
package pwm_dac_pkg;

   function automatic int code_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   function automatic int win_last(input int cycles);
      return cycles - 1;
   endfunction

   function automatic logic [31:0] clamp(input logic [31:0] code, input logic [31:0] max);
      return (code > max) ? max : code;
   endfunction

endpackage

// File: rtl/pwm_dac_chan.sv
// pwm_dac_chan: one PWM channel with pending/active duty and registered compare.
// PWM_DAC_CENTER_ALIGN_EN centres the pulse inside the window.
module pwm_dac_chan
   import pwm_dac_pkg::*;
#(
   parameter int CYCLES = 1024,
   parameter int CW     = code_w(CYCLES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          store_i,
   input  logic          load_i,
   input  logic [CW-1:0] cnt_i,
   input  logic [CW-1:0] code_i,
   output logic          pwm_o
);
   localparam logic [CW-1:0] FULL = CW'(CYCLES);

   logic [CW-1:0] pend_q, act_q;
   logic          pwm_q, hit;

`ifdef PWM_DAC_CENTER_ALIGN_EN
   logic [CW-1:0] lo_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lo_q <= '0;
      else if (load_i) lo_q <= (FULL - pend_q) >> 1;
   // lo_q + act_q never exceeds CYCLES, so it cannot wrap in CW bits
   assign hit = (cnt_i >= lo_q) && (cnt_i < lo_q + act_q);
`else
   assign hit = cnt_i < act_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         act_q  <= '0;
         pwm_q  <= 1'b0;
      end else begin
         if (store_i) pend_q <= CW'(clamp(32'(code_i), 32'(CYCLES)));
         if (load_i) act_q <= pend_q;
         pwm_q <= en_i & hit;
      end
   end

   assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_dac_multi.sv
// pwm_dac_multi: multi-channel PWM DAC, shared window counter, one double-buffered frame per window.
// Define PWM_DAC_CENTER_ALIGN_EN for centre-aligned pulses.
module pwm_dac_multi
   import pwm_dac_pkg::*;
#(
   parameter int NUM_CH            = 2,
   parameter int CYCLES_PER_WINDOW = 1024,
   parameter int CODE_WIDTH        = code_w(CYCLES_PER_WINDOW)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [NUM_CH*CODE_WIDTH-1:0] s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic                         next_sample,
   output logic                         underrun,
   output logic [NUM_CH-1:0]            pwm
);
   localparam logic [CODE_WIDTH-1:0] LAST = CODE_WIDTH'(win_last(CYCLES_PER_WINDOW));

   logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
   logic                  pend_vld_q, pend_vld_d, next_sample_q, underrun_q, ns_d;
   logic                  xfer, win_end;

   always_comb begin
      xfer       = s_valid & ~pend_vld_q;
      win_end    = en & (cnt_q == LAST);
      cnt_d      = (en & ~win_end) ? cnt_q + CODE_WIDTH'(1) : '0;
      pend_vld_d = xfer | (pend_vld_q & ~win_end);
      ns_d       = en & (cnt_d == LAST);
   end

   // both pulses are computed one cycle early so they sit on the last window cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         pend_vld_q    <= 1'b0;
         next_sample_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         pend_vld_q    <= pend_vld_d;
         next_sample_q <= ns_d;
         underrun_q    <= ns_d & ~pend_vld_d;
      end
   end

   assign s_ready     = ~pend_vld_q;
   assign next_sample = next_sample_q;
   assign underrun    = underrun_q;

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         pwm_dac_chan #(.CYCLES(CYCLES_PER_WINDOW), .CW(CODE_WIDTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en),
            .store_i (xfer),
            .load_i  (win_end & pend_vld_q),
            .cnt_i   (cnt_q),
            .code_i  (s_data[i*CODE_WIDTH +: CODE_WIDTH]),
            .pwm_o   (pwm[i])
         );
      end
   endgenerate
endmodule

// File: tb/tb_pwm_dac_multi.sv
// tb_pwm_dac_multi: randomized and directed bench for pwm_dac_multi against a window-level reference model.
module tb_pwm_dac_multi;
   localparam int C  = 16;
   localparam int N  = 2;
   localparam int W  = 5;
   localparam int DW = N * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, next_sample, underrun;
   logic [N-1:0]  pwm;

   always #5 clk = ~clk;

   pwm_dac_multi #(.NUM_CH(N), .CYCLES_PER_WINDOW(C)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .next_sample (next_sample),
      .underrun    (underrun),
      .pwm         (pwm)
   );

   int n_chk = 0, n_fail = 0;

   int       m_pos;
   bit       m_pv, m_ns, m_ur, m_xfer;
   int       m_pend[N], m_act[N];
   bit [N-1:0] m_pwm;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int start_of(input int d);
`ifdef PWM_DAC_CENTER_ALIGN_EN
      return (C - d) / 2;
`else
      return 0;
`endif
   endfunction

   function automatic bit in_pulse(input int p, input int d);
      return p >= start_of(d) && p < start_of(d) + d;
   endfunction

   function automatic int clampi(input int c);
      return c > C ? C : c;
   endfunction

   task automatic m_reset();
      m_pos = 0; m_pv = 0; m_ns = 0; m_ur = 0; m_pwm = '0;
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_act[i] = 0; end
   endtask

   // one clock: model advances from the inputs seen at the edge, then DUT is compared
   task automatic tick();
      int npos, nact[N], npend[N];
      bit last, npv;
      bit [N-1:0] npwm;
      m_xfer = s_valid && !m_pv;
      last = en && m_pos == C - 1;
      for (int i = 0; i < N; i++) begin
         npwm[i]  = en && in_pulse(m_pos, m_act[i]);
         nact[i]  = (last && m_pv) ? m_pend[i] : m_act[i];
         npend[i] = m_xfer ? clampi(int'(s_data[i*W +: W])) : m_pend[i];
      end
      npv  = m_xfer || (m_pv && !last);
      npos = en ? (m_pos + 1) % C : 0;
      @(posedge clk); #1;
      m_pos = npos; m_pv = npv; m_pwm = npwm;
      for (int i = 0; i < N; i++) begin m_act[i] = nact[i]; m_pend[i] = npend[i]; end
      m_ns = (npos == C - 1);
      m_ur = m_ns && !npv;
      chk("pwm", pwm, m_pwm);
      chk("next_sample", next_sample, m_ns);
      chk("underrun", underrun, m_ur);
      chk("s_ready", s_ready, !m_pv);
   endtask

   task automatic send(input int c0, input int c1, input bit keep);
      int k = 0;
      s_data = {W'(c1), W'(c0)};
      s_valid = 1'b1;
      do begin tick(); k++; end while (!m_xfer && k < 64);
      chk("accept", m_xfer, 1);
      s_valid = keep;
   endtask

   task automatic run_window(input string tag, input int d0, input int d1);
      int h[N], first[N], d[N];
      int k = 0;
      d[0] = d0; d[1] = d1;
      while ((m_pv || m_pos != 0) && k < 64) begin tick(); k++; end
      chk({tag, "_align"}, k < 64, 1);
      for (int i = 0; i < N; i++) begin h[i] = 0; first[i] = -1; end
      for (int j = 0; j < C; j++) begin
         tick();
         for (int i = 0; i < N; i++) if (pwm[i]) begin
            h[i]++;
            if (first[i] < 0) first[i] = j;
         end
      end
      for (int i = 0; i < N; i++) begin
         chk({tag, "_high"}, h[i], d[i]);
         if (d[i] > 0) chk({tag, "_start"}, first[i], start_of(d[i]));
      end
   endtask

   task automatic wait_pos(input int p);
      int k = 0;
      while (m_pos != p && k < 64) begin tick(); k++; end
      chk("wait_pos", m_pos, p);
   endtask

   initial begin
      int ur_cnt;
      #12;
      chk("rst_pwm", pwm, 0);
      chk("rst_ns", next_sample, 0);
      chk("rst_ur", underrun, 0);
      chk("rst_ready", s_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      en = 1'b1;

      ur_cnt = 0;
      for (int j = 0; j < 3 * C; j++) begin tick(); ur_cnt += int'(underrun); end
      chk("underrun_cnt", ur_cnt, 3);

      wait_pos(3);
      send(10, 4, 0);
      run_window("w_10_4", 10, 4);
      send(16, 0, 0);
      run_window("w_16_0", 16, 0);
      send(6, 31, 0);
      run_window("w_6_31", 6, 16);
      send(5, 1, 0);
      run_window("w_5_1", 5, 1);

      for (int f = 0; f < 6; f++) send($urandom_range(0, 31), $urandom_range(0, 31), f != 5);
      send(7, 12, 0);
      run_window("w_7_12", 7, 12);

      wait_pos(7);
      en = 1'b0;
      repeat (5) tick();
      chk("en_low_pwm", pwm, 0);
      en = 1'b1;
      run_window("w_resume", 7, 12);

      wait_pos(2);
      send(9, 3, 0);
      wait_pos(6);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_pwm", pwm, 0);
      chk("arst_ns", next_sample, 0);
      chk("arst_ur", underrun, 0);
      chk("arst_ready", s_ready, 1);
      m_reset();
      #2 rst_n = 1'b1;
      run_window("w_after_rst", 0, 0);

      for (int j = 0; j < 600; j++) begin
         en = $urandom_range(0, 9) != 0;
         s_valid = $urandom_range(0, 2) == 0;
         s_data = DW'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
